// File: rtl/ysyx_23060025_wbu.sv
// Write-back unit: commits one retired instruction per LSU handshake.
// It writes the GPR, updates the CSRs for CSRW, ECALL and MRET, pulses ebreak,
// and tells the IFU that it may fetch the next instruction.
// It owns the machine CSR file and the 64-bit minstret counter.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   lsu_valid_i / wbu_ready_o    LSU -> WBU handshake
//   wd_i, wreg_i, wdata_i        GPR write request of the retiring instruction
//   csr_type_i, csr_waddr_i,
//   csr_wdata_i                  CSR operation (none/CSRW/ECALL/MRET), its address and its data
//   ebreak_flag_i                the instruction is an ebreak
//   rf_wen_o, rf_waddr_o,
//   rf_wdata_o                   GPR write port (one-cycle strobe)
//   csr_raddr_i / csr_rdata_o    combinational CSR read port for the EXU
//   mtvec_o, mepc_o              trap and return targets
//   ebreak_o                     ebreak committed (one-cycle pulse)
//   wbu_valid_o / ifu_ready_i    retire notification handshake to the IFU
module ysyx_23060025_wbu #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned ADDR_LEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                lsu_valid_i,
  output logic                wbu_ready_o,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [2:0]          csr_type_i,
  input  logic [11:0]         csr_waddr_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  input  logic                ebreak_flag_i,
  output logic                rf_wen_o,
  output logic [4:0]          rf_waddr_o,
  output logic [DATA_LEN-1:0] rf_wdata_o,
  input  logic [11:0]         csr_raddr_i,
  output logic [DATA_LEN-1:0] csr_rdata_o,
  output logic [ADDR_LEN-1:0] mtvec_o,
  output logic [ADDR_LEN-1:0] mepc_o,
  output logic                ebreak_o,
  output logic                wbu_valid_o,
  input  logic                ifu_ready_i
);

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CSR_AW = 12;
  localparam int unsigned CNT_W  = 64;

  localparam logic [2:0] CSR_T_W     = 3'b001;
  localparam logic [2:0] CSR_T_ECALL = 3'b010;
  localparam logic [2:0] CSR_T_MRET  = 3'b011;

  localparam logic [CSR_AW-1:0] A_MSTATUS   = 12'h300;
  localparam logic [CSR_AW-1:0] A_MTVEC     = 12'h305;
  localparam logic [CSR_AW-1:0] A_MEPC      = 12'h341;
  localparam logic [CSR_AW-1:0] A_MCAUSE    = 12'h342;
  localparam logic [CSR_AW-1:0] A_MINSTRET  = 12'hB02;
  localparam logic [CSR_AW-1:0] A_MINSTRETH = 12'hB82;
  localparam logic [CSR_AW-1:0] A_MVENDORID = 12'hF11;
  localparam logic [CSR_AW-1:0] A_MARCHID   = 12'hF12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   accept_c, commit_c;

  logic                wbu_ready_q, wbu_valid_q, rf_wen_q, ebreak_q;
  logic [REG_AW-1:0]   rf_waddr_q;
  logic [DATA_LEN-1:0] rf_wdata_q;
  logic [2:0]          csr_type_q;
  logic [CSR_AW-1:0]   csr_waddr_q;
  logic [DATA_LEN-1:0] csr_wdata_q;

  logic [DATA_LEN-1:0] mstatus_q, mcause_q;
  logic [ADDR_LEN-1:0] mtvec_q, mepc_q;
  logic [CNT_W-1:0]    minstret_q, minstret_inc_c;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; COMMIT always lasts exactly one cycle
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lsu_valid_i) begin
          accept_c = 1'b1;
          state_d  = S_COMMIT;
        end
      end
      S_COMMIT: begin
        commit_c = 1'b1;
        state_d  = ifu_ready_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (ifu_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs and instruction capture; strobes are high only in COMMIT
  always_ff @(posedge clock) begin
    if (reset) begin
      wbu_ready_q <= 1'b1;
      wbu_valid_q <= 1'b0;
      rf_wen_q    <= 1'b0;
      ebreak_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      csr_type_q  <= '0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
    end else begin
      wbu_ready_q <= (state_d == S_IDLE);
      wbu_valid_q <= (state_d != S_IDLE);
      rf_wen_q    <= accept_c & wd_i & (wreg_i != '0);
      ebreak_q    <= accept_c & ebreak_flag_i;
      if (accept_c) begin
        rf_waddr_q  <= wreg_i;
        rf_wdata_q  <= wdata_i;
        csr_type_q  <= csr_type_i;
        csr_waddr_q <= csr_waddr_i;
        csr_wdata_q <= csr_wdata_i;
      end
    end
  end

  assign minstret_inc_c = minstret_q + CNT_W'(1);

  // CSR file update on the COMMIT exit edge; a CSRW to a minstret half overrides the increment
  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_q  <= DATA_LEN'(32'h0000_1800);
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      minstret_q <= '0;
    end else if (commit_c) begin
      minstret_q <= minstret_inc_c;
      case (csr_type_q)
        CSR_T_W: begin
          case (csr_waddr_q)
            A_MSTATUS:   mstatus_q <= csr_wdata_q;
            A_MTVEC:     mtvec_q   <= ADDR_LEN'(csr_wdata_q);
            A_MEPC:      mepc_q    <= ADDR_LEN'(csr_wdata_q);
            A_MCAUSE:    mcause_q  <= csr_wdata_q;
            A_MINSTRET:  minstret_q <= {minstret_inc_c[63:32], 32'(csr_wdata_q)};
            A_MINSTRETH: minstret_q <= {32'(csr_wdata_q), minstret_inc_c[31:0]};
            default: ;
          endcase
        end
        CSR_T_ECALL: begin
          mepc_q            <= ADDR_LEN'(csr_wdata_q);
          mcause_q          <= DATA_LEN'(11);
          mstatus_q[7]      <= mstatus_q[3];
          mstatus_q[3]      <= 1'b0;
          mstatus_q[12:11]  <= 2'b11;
        end
        CSR_T_MRET: begin
          mstatus_q[3]      <= mstatus_q[7];
          mstatus_q[7]      <= 1'b1;
          mstatus_q[12:11]  <= 2'b11;
        end
        default: ;
      endcase
    end
  end

  // Combinational CSR read; sees only committed state
  always_comb begin
    csr_rdata_o = '0;
    case (csr_raddr_i)
      A_MSTATUS:   csr_rdata_o = mstatus_q;
      A_MTVEC:     csr_rdata_o = DATA_LEN'(mtvec_q);
      A_MEPC:      csr_rdata_o = DATA_LEN'(mepc_q);
      A_MCAUSE:    csr_rdata_o = mcause_q;
      A_MINSTRET:  csr_rdata_o = DATA_LEN'(minstret_q[31:0]);
      A_MINSTRETH: csr_rdata_o = DATA_LEN'(minstret_q[63:32]);
      A_MVENDORID: csr_rdata_o = DATA_LEN'(32'h7973_7978);
      A_MARCHID:   csr_rdata_o = DATA_LEN'(32'h015F_DE39);
      default:     csr_rdata_o = '0;
    endcase
  end

  assign wbu_ready_o = wbu_ready_q;
  assign wbu_valid_o = wbu_valid_q;
  assign rf_wen_o    = rf_wen_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;
  assign ebreak_o    = ebreak_q;
  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;

endmodule
